spi_master: RTL
===============

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 SHALL provide parameter TURN, default 2, range 0..15: turnaround cycles between last MOSI bit and first MISO sample in a read-data frame.
REQ-002 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL provide port start  input  1  host request; sampled only in IDLE.
REQ-005 SHALL provide port cmd_data  input  10  frame to send; [9:8] = command (00 wr addr, 01 wr data, 10 rd addr, 11 rd data), [7:0] = payload.
REQ-006 SHALL provide port busy  output  1  high from accept cycle +1 until done cycle inclusive.
REQ-007 SHALL provide port done  output  1  one-cycle pulse at frame end.
REQ-008 SHALL provide port rd_data  output  8  byte captured from MISO during a read-data frame.
REQ-009 SHALL provide port rd_valid  output  1  one-cycle pulse, coincident with done, for read-data frames only.
REQ-010 SHALL provide port SS_n  output  1  slave select, active-low, registered.
REQ-011 SHALL provide port MOSI  output  1  serial data to slave, registered.
REQ-012 SHALL provide port MISO  input  1  serial data from slave.

Function
REQ-013 SHALL implement states IDLE, SEL, CMD, SHIFT, TURNWAIT, READ, END.
REQ-014 IDLE: SS_n=1, MOSI=0; start=1 latches cmd_data into a 10-bit shift register, moves to SEL.
REQ-015 SEL (1 cycle): SS_n=0, MOSI=cmd[9]; moves to CMD.
REQ-016 CMD (1 cycle): SS_n=0, MOSI=cmd[9]; moves to SHIFT with 4-bit bit counter cleared.
REQ-017 SHIFT (exactly 10 cycles): MOSI drives cmd[9] down to cmd[0], MSB first, one bit per cycle.
REQ-018 After SHIFT: cmd[9:8]==11 goes to TURNWAIT (or READ directly when TURN=0); all other commands go to END.
REQ-019 TURNWAIT (TURN cycles): SS_n=0, MOSI=0.
REQ-020 READ (exactly 8 cycles): SS_n=0, MOSI=0, MISO sampled each cycle and shifted into rd_data MSB first.
REQ-021 END (1 cycle): SS_n=1, MOSI=0, done=1, rd_valid=1 if frame was read-data; moves to IDLE.
REQ-022 Frame length with SS_n low: 12 cycles for non-read-data, 20+TURN cycles for read-data; SS_n is high for at least 2 cycles (END plus IDLE) between frames.
REQ-023 start asserted in any state other than IDLE SHALL be ignored; cmd_data changes after accept SHALL NOT affect the frame.
REQ-024 rd_data SHALL hold its value until the next read-data frame completes; non-read frames SHALL NOT modify it.
REQ-025 start asserted in the END cycle SHALL be ignored; it is accepted only in the following IDLE cycle.

Reset
REQ-026 rst=1 SHALL immediately force state IDLE, SS_n=1, MOSI=0, busy=0, done=0, rd_valid=0, rd_data=0, counters and shift register 0.
REQ-027 rst asserted mid-frame SHALL abort the frame without a done pulse; SS_n rises asynchronously.

Configuration
REQ-028 Macro SPI_MASTER_OVR_EN defined: SHALL add output ovr_err (1 bit, reset 0), pulsing for one cycle whenever start=1 while state is not IDLE.
REQ-029 Macro SPI_MASTER_OVR_EN undefined: port ovr_err SHALL NOT exist; ignored starts leave no trace.

Verification
REQ-030 Write-data: start with cmd_data=10'b01_1010_0101 -> SS_n low 12 cycles, MOSI sequence 0,0,0,1,1,0,1,0,0,1,0,1, then done=1, rd_valid=0.
REQ-031 Read-data, TURN=2: cmd_data=10'b11_0000_0000, MISO drives 8'hC3 MSB first during READ -> SS_n low 22 cycles, rd_data=8'hC3, rd_valid and done pulse together.
REQ-032 Back-to-back: start held high continuously -> second frame's SEL begins exactly 2 cycles after first frame's last SS_n-low cycle.
REQ-033 start pulsed during SHIFT -> frame unchanged; ovr_err pulses once when SPI_MASTER_OVR_EN defined.
REQ-034 rst asserted during READ bit 4 -> SS_n=1 and rd_data=0 immediately, no done; next start runs a full normal frame.
REQ-035 TURN=0 read-data frame -> READ follows SHIFT with no gap, SS_n low 20 cycles.

Source files
------------

// File: rtl/spi_master_if.sv
// Host/serial bundle for spi_master.
// Optional ovr_err signal is present only when SPI_MASTER_OVR_EN is defined.
interface spi_master_if;
    logic       start;
    logic [9:0] cmd_data;
    logic       busy;
    logic       done;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       SS_n;
    logic       MOSI;
    logic       MISO;
`ifdef SPI_MASTER_OVR_EN
    logic       ovr_err;

    modport master (
        input  start, cmd_data, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI, ovr_err
    );
    modport slave (
        output start, cmd_data, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI, ovr_err
    );
`else
    modport master (
        input  start, cmd_data, MISO,
        output busy, done, rd_data, rd_valid, SS_n, MOSI
    );
    modport slave (
        output start, cmd_data, MISO,
        input  busy, done, rd_data, rd_valid, SS_n, MOSI
    );
`endif
endinterface

// File: rtl/spi_master.sv
// SPI master: sends a 10-bit command frame MSB first and, for read-data
// frames, waits TURN cycles then captures one byte from MISO.
// Optional feature macro: SPI_MASTER_OVR_EN adds the ovr_err pulse output
// flagging start requests that arrive while a frame is in progress.
module spi_master #(
    parameter int TURN = 2
) (
    input  logic          clk,
    input  logic          rst,
    spi_master_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SEL      = 3'd1,
        CMD      = 3'd2,
        SHIFT    = 3'd3,
        TURNWAIT = 3'd4,
        READ     = 3'd5,
        END      = 3'd6
    } state_t;

    // Last turnaround count; unused (and harmless) when TURN is 0.
    localparam logic [3:0] TURN_LAST = 4'(TURN - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [9:0] sr_q, sr_d;
    logic       is_rd_q, is_rd_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] rd_data_q, rd_data_d;
    logic       ss_n_q, ss_n_d;
    logic       mosi_q, mosi_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       rd_valid_q, rd_valid_d;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (bus.start) state_d = SEL;
                else           state_d = IDLE;
            end
            SEL:  state_d = CMD;
            CMD:  state_d = SHIFT;
            SHIFT: begin
                if (cnt_q == 4'd9) begin
                    if (is_rd_q) begin
                        if (TURN == 0) state_d = READ;
                        else           state_d = TURNWAIT;
                    end else begin
                        state_d = END;
                    end
                end else begin
                    state_d = SHIFT;
                end
            end
            TURNWAIT: begin
                if (cnt_q == TURN_LAST) state_d = READ;
                else                    state_d = TURNWAIT;
            end
            READ: begin
                if (cnt_q == 4'd7) state_d = END;
                else               state_d = READ;
            end
            END:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath next values: bit counter, command shifter, MISO capture.
    always_comb begin
        sr_d      = sr_q;
        is_rd_d   = is_rd_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        // Counter runs while staying in a timed state, clears on any change.
        if ((state_d == state_q) &&
            ((state_q == SHIFT) || (state_q == TURNWAIT) || (state_q == READ))) begin
            cnt_d = cnt_q + 4'd1;
        end else begin
            cnt_d = 4'd0;
        end
        if ((state_q == IDLE) && bus.start) begin
            sr_d    = bus.cmd_data;
            is_rd_d = (bus.cmd_data[9:8] == 2'b11);
            rx_d    = 7'd0;
        end else if (state_q == SHIFT) begin
            sr_d = {sr_q[8:0], 1'b0};
        end else if (state_q == READ) begin
            rx_d = {rx_q[5:0], bus.MISO};
        end else begin
            sr_d = sr_q;
        end
        // rd_data only changes when a read-data frame completes.
        if ((state_q == READ) && (state_d == END)) begin
            rd_data_d = {rx_q, bus.MISO};
        end else begin
            rd_data_d = rd_data_q;
        end
    end

    // Output decode from the upcoming state so the registered pins line up
    // with the state they belong to.
    always_comb begin
        ss_n_d     = 1'b1;
        mosi_d     = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;
        rd_valid_d = 1'b0;
        case (state_d)
            IDLE: begin
                ss_n_d = 1'b1;
            end
            SEL, CMD, SHIFT: begin
                ss_n_d = 1'b0;
                mosi_d = sr_d[9];
                busy_d = 1'b1;
            end
            TURNWAIT, READ: begin
                ss_n_d = 1'b0;
                busy_d = 1'b1;
            end
            END: begin
                busy_d     = 1'b1;
                done_d     = 1'b1;
                rd_valid_d = is_rd_q;
            end
            default: begin
                ss_n_d = 1'b1;
            end
        endcase
    end

    // Datapath and output registers; reset aborts any frame immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= 4'd0;
            sr_q       <= 10'd0;
            is_rd_q    <= 1'b0;
            rx_q       <= 7'd0;
            rd_data_q  <= 8'd0;
            ss_n_q     <= 1'b1;
            mosi_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            sr_q       <= sr_d;
            is_rd_q    <= is_rd_d;
            rx_q       <= rx_d;
            rd_data_q  <= rd_data_d;
            ss_n_q     <= ss_n_d;
            mosi_q     <= mosi_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign bus.SS_n     = ss_n_q;
    assign bus.MOSI     = mosi_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

`ifdef SPI_MASTER_OVR_EN
    logic ovr_err_q, ovr_err_d;

    // Flag a start request that arrives while a frame is still running.
    always_comb begin
        if (bus.start && (state_q != IDLE)) ovr_err_d = 1'b1;
        else                                ovr_err_d = 1'b0;
    end

    // Overrun pulse register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovr_err_q <= 1'b0;
        end else begin
            ovr_err_q <= ovr_err_d;
        end
    end

    assign bus.ovr_err = ovr_err_q;
`endif

endmodule
